// File: rtl/cp0_reg.sv
// CP0 coprocessor register file for a MIPS-style core.
// Holds the BadVAddr, Count, Compare, Status, Cause and EPC registers.
// Handles exception entry, ERET return, the Count/Compare timer interrupt
// and the registered pipeline-flush redirect.
module cp0_reg #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
   parameter int          COUNT_DIV = 2
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        wb_cp0_we,
   input  logic [4:0]  wb_cp0_waddr,
   input  logic [31:0] wb_cp0_wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   input  logic [5:0]  int_i,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_in_delay,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret,
   output logic        int_req,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   // Timer state
   logic [31:0]      r_count;
   logic [31:0]      r_compare;
   logic [DIV_W-1:0] r_div;
   logic             r_ti;

   // Status fields (BEV is a constant 1 and not stored)
   logic [7:0]       r_status_im;
   logic             r_status_exl;
   logic             r_status_ie;

   // Cause fields
   logic             r_cause_bd;
   logic [5:0]       r_cause_ip_hw;
   logic [1:0]       r_cause_ip_sw;
   logic [4:0]       r_cause_exccode;

   // Exception bookkeeping
   logic [31:0]      r_epc;
   logic [31:0]      r_badvaddr;

   // Redirect outputs
   logic             r_flush;
   logic [31:0]      r_flush_pc;

   logic             w_wr_count;
   logic             w_wr_compare;
   logic             w_wr_status;
   logic             w_wr_cause;
   logic             w_wr_epc;
   logic             w_div_tc;
   logic             w_count_match;
   logic             w_exc_addr_fault;
   logic [31:0]      w_exc_epc;
   logic [7:0]       w_cause_ip;

   // Write-port decode; BadVAddr and unlisted numbers are never written
   assign w_wr_count   = wb_cp0_we && (wb_cp0_waddr == REG_COUNT);
   assign w_wr_compare = wb_cp0_we && (wb_cp0_waddr == REG_COMPARE);
   assign w_wr_status  = wb_cp0_we && (wb_cp0_waddr == REG_STATUS);
   assign w_wr_cause   = wb_cp0_we && (wb_cp0_waddr == REG_CAUSE);
   assign w_wr_epc     = wb_cp0_we && (wb_cp0_waddr == REG_EPC);

   assign w_div_tc         = (r_div == DIV_W'(COUNT_DIV - 1));
   assign w_count_match    = (r_count == r_compare);
   assign w_exc_addr_fault = (exc_code == EXC_ADEL) || (exc_code == EXC_ADES);
   assign w_exc_epc        = exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
   assign w_cause_ip       = {r_cause_ip_hw, r_cause_ip_sw};

   assign status_o = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0, r_status_exl, r_status_ie};
   assign cause_o  = {r_cause_bd, r_ti, 14'b0, r_cause_ip_hw, r_cause_ip_sw,
                      1'b0, r_cause_exccode, 2'b0};
   assign epc_o    = r_epc;
   assign flush    = r_flush;
   assign flush_pc = r_flush_pc;

   assign int_req = r_status_ie & ~r_status_exl & (|(w_cause_ip & r_status_im));

   // MFC0 read mux; unimplemented numbers read as zero
   always_comb begin
      rdata = 32'd0;
      case (raddr)
         REG_BADVADDR: rdata = r_badvaddr;
         REG_COUNT:    rdata = r_count;
         REG_COMPARE:  rdata = r_compare;
         REG_STATUS:   rdata = status_o;
         REG_CAUSE:    rdata = cause_o;
         REG_EPC:      rdata = r_epc;
         default:      rdata = 32'd0;
      endcase
   end

   // Count advances once per COUNT_DIV cycles; a software load restarts the divider phase
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_count <= 32'd0;
         r_div   <= '0;
      end else if (w_wr_count) begin
         r_count <= wb_cp0_wdata;
         r_div   <= '0;
      end else if (w_div_tc) begin
         r_count <= r_count + 32'd1;
         r_div   <= '0;
      end else begin
         r_div   <= r_div + DIV_W'(1);
      end
   end

   // Compare register and timer interrupt flag; a Compare write beats a same-cycle match
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_compare <= 32'd0;
         r_ti      <= 1'b0;
      end else if (w_wr_compare) begin
         r_compare <= wb_cp0_wdata;
         r_ti      <= 1'b0;
      end else if (w_count_match) begin
         r_ti      <= 1'b1;
      end
   end

   // Status: software write first, then ERET, then exception, so the later assignment wins on EXL
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_status_im  <= 8'd0;
         r_status_exl <= 1'b0;
         r_status_ie  <= 1'b0;
      end else begin
         if (w_wr_status) begin
            r_status_im  <= wb_cp0_wdata[15:8];
            r_status_exl <= wb_cp0_wdata[1];
            r_status_ie  <= wb_cp0_wdata[0];
         end
         if (eret) begin
            r_status_exl <= 1'b0;
         end
         if (exc_valid) begin
            r_status_exl <= 1'b1;
         end
      end
   end

   // Cause: hardware IP lines resampled every cycle, software IP via MTC0, BD/ExcCode on exception
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_cause_bd      <= 1'b0;
         r_cause_ip_hw   <= 6'd0;
         r_cause_ip_sw   <= 2'd0;
         r_cause_exccode <= 5'd0;
      end else begin
         r_cause_ip_hw <= {int_i[5] | r_ti, int_i[4:0]};
         if (w_wr_cause) begin
            r_cause_ip_sw <= wb_cp0_wdata[9:8];
         end
         if (exc_valid) begin
            r_cause_exccode <= exc_code;
            if (!r_status_exl) begin
               r_cause_bd <= exc_in_delay;
            end
         end
      end
   end

   // EPC and BadVAddr; a nested exception (EXL already set) keeps the original return address
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_epc      <= 32'd0;
         r_badvaddr <= 32'd0;
      end else begin
         if (exc_valid && !r_status_exl) begin
            r_epc <= w_exc_epc;
         end else if (w_wr_epc) begin
            r_epc <= wb_cp0_wdata;
         end
         if (exc_valid && w_exc_addr_fault) begin
            r_badvaddr <= exc_badvaddr;
         end
      end
   end

   // One-cycle flush pulse with the redirect target; target holds between flushes
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_flush    <= 1'b0;
         r_flush_pc <= 32'd0;
      end else begin
         r_flush <= exc_valid | eret;
         if (exc_valid) begin
            r_flush_pc <= EXC_ENTRY;
         end else if (eret) begin
            r_flush_pc <= r_epc;
         end
      end
   end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, Count/Compare timer, interrupts,
// exception entry (plain and nested), ERET, same-cycle priority and async reset.
module tb_cp0_reg;

   logic        clk;
   logic        rst;
   logic        wb_cp0_we;
   logic [4:0]  wb_cp0_waddr;
   logic [31:0] wb_cp0_wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic [5:0]  int_i;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_in_delay;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic        int_req;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;

   int n_tests = 0;
   int n_fail  = 0;

   cp0_reg dut (
      .cpu_clk_50M  (clk),
      .cpu_rst      (rst),
      .wb_cp0_we    (wb_cp0_we),
      .wb_cp0_waddr (wb_cp0_waddr),
      .wb_cp0_wdata (wb_cp0_wdata),
      .raddr        (raddr),
      .rdata        (rdata),
      .int_i        (int_i),
      .exc_valid    (exc_valid),
      .exc_code     (exc_code),
      .exc_pc       (exc_pc),
      .exc_in_delay (exc_in_delay),
      .exc_badvaddr (exc_badvaddr),
      .eret         (eret),
      .int_req      (int_req),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .status_o     (status_o),
      .cause_o      (cause_o),
      .epc_o        (epc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      raddr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wb_cp0_we    = 1'b1;
      wb_cp0_waddr = a;
      wb_cp0_wdata = d;
      tick();
      wb_cp0_we    = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      wb_cp0_we    = 1'b0;
      wb_cp0_waddr = 5'd0;
      wb_cp0_wdata = 32'd0;
      raddr        = 5'd0;
      int_i        = 6'd0;
      exc_valid    = 1'b0;
      exc_code     = 5'd0;
      exc_pc       = 32'd0;
      exc_in_delay = 1'b0;
      exc_badvaddr = 32'd0;
      eret         = 1'b0;

      // Reset values
      ticks(2);
      chk("rst_status", status_o, 32'h0040_0000);
      chk("rst_cause", cause_o, 32'd0);
      chk("rst_epc", epc_o, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_flush_pc", flush_pc, 32'd0);
      chk("rst_int_req", {31'd0, int_req}, 32'd0);

      rst = 1'b0;
      rd("rd_status", 5'd12, 32'h0040_0000);
      ticks(10);
      rd("count_after_10", 5'd9, 32'd5);

      // Timer interrupt: Compare=3, Count=0, match after 3 increments
      wr(5'd11, 32'd3);
      chk("ti_cleared_by_cmp", {31'd0, cause_o[30]}, 32'd0);
      wr(5'd9, 32'd0);
      rd("count_loaded", 5'd9, 32'd0);
      ticks(10);
      chk("ti_set", {31'd0, cause_o[30]}, 32'd1);
      chk("ip7_set", {31'd0, cause_o[15]}, 32'd1);
      chk("int_req_masked", {31'd0, int_req}, 32'd0);
      wr(5'd12, 32'h0000_8001);
      chk("status_im7_ie", status_o, 32'h0040_8001);
      chk("int_req_on", {31'd0, int_req}, 32'd1);
      wr(5'd11, 32'd3);
      chk("ti_rewrite_clear", {31'd0, cause_o[30]}, 32'd0);
      tick();
      chk("ip7_clear", {31'd0, cause_o[15]}, 32'd0);
      chk("int_req_off", {31'd0, int_req}, 32'd0);

      // Compare write in the same cycle as a match: the write wins
      wr(5'd11, 32'd20);
      wr(5'd9, 32'd20);
      wr(5'd11, 32'd20);
      chk("cmp_write_beats_match", {31'd0, cause_o[30]}, 32'd0);
      tick();
      chk("match_sets_ti", {31'd0, cause_o[30]}, 32'd1);
      wr(5'd11, 32'h0000_1000);

      // Exception in delay slot
      exc_valid    = 1'b1;
      exc_code     = 5'h0C;
      exc_pc       = 32'hBFC0_0100;
      exc_in_delay = 1'b1;
      exc_badvaddr = 32'h0000_1234;
      tick();
      exc_valid    = 1'b0;
      chk("exc1_epc", epc_o, 32'hBFC0_00FC);
      chk("exc1_bd", {31'd0, cause_o[31]}, 32'd1);
      chk("exc1_exl", {31'd0, status_o[1]}, 32'd1);
      chk("exc1_code", {27'd0, cause_o[6:2]}, 32'h0C);
      chk("exc1_flush", {31'd0, flush}, 32'd1);
      chk("exc1_flush_pc", flush_pc, 32'hBFC0_0380);
      chk("exc1_int_req", {31'd0, int_req}, 32'd0);
      rd("exc1_badvaddr_kept", 5'd8, 32'd0);
      tick();
      chk("exc1_flush_pulse", {31'd0, flush}, 32'd0);

      // Nested AdEL exception: EPC/BD kept, ExcCode and BadVAddr updated
      exc_valid    = 1'b1;
      exc_code     = 5'h04;
      exc_pc       = 32'h8000_0010;
      exc_in_delay = 1'b0;
      exc_badvaddr = 32'hDEAD_BEEF;
      tick();
      exc_valid    = 1'b0;
      chk("exc2_epc_kept", epc_o, 32'hBFC0_00FC);
      chk("exc2_bd_kept", {31'd0, cause_o[31]}, 32'd1);
      chk("exc2_code", {27'd0, cause_o[6:2]}, 32'h04);
      rd("exc2_badvaddr", 5'd8, 32'hDEAD_BEEF);

      // ERET
      eret = 1'b1;
      tick();
      eret = 1'b0;
      chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
      chk("eret_flush", {31'd0, flush}, 32'd1);
      chk("eret_flush_pc", flush_pc, 32'hBFC0_00FC);

      // Exception and Status write (EXL=0) together: EXL set, IM/IE from write
      exc_valid    = 1'b1;
      exc_code     = 5'h08;
      exc_pc       = 32'h0000_0100;
      exc_in_delay = 1'b0;
      wr(5'd12, 32'h0000_8001);
      exc_valid    = 1'b0;
      chk("prio_status", status_o, 32'h0040_8003);
      chk("prio_epc", epc_o, 32'h0000_0100);
      chk("prio_bd", {31'd0, cause_o[31]}, 32'd0);

      // Exception and Count write together: disjoint, both apply
      exc_valid    = 1'b1;
      exc_code     = 5'h09;
      exc_pc       = 32'h0000_0200;
      wr(5'd9, 32'h0000_0055);
      exc_valid    = 1'b0;
      rd("prio_count", 5'd9, 32'h0000_0055);
      chk("prio_epc_nested", epc_o, 32'h0000_0100);
      chk("prio_code", {27'd0, cause_o[6:2]}, 32'h09);

      // Writes to read-only / unimplemented numbers
      wr(5'd8, 32'h0000_0000);
      rd("badvaddr_ro", 5'd8, 32'hDEAD_BEEF);
      wr(5'd5, 32'hFFFF_FFFF);
      rd("unimpl_reads_zero", 5'd5, 32'd0);

      // Async reset mid-operation with TI pending
      wr(5'd11, 32'h0000_0060);
      wr(5'd9, 32'h0000_0060);
      tick();
      chk("pre_rst_ti", {31'd0, cause_o[30]}, 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_status", status_o, 32'h0040_0000);
      chk("arst_cause", cause_o, 32'd0);
      chk("arst_epc", epc_o, 32'd0);
      chk("arst_flush_pc", flush_pc, 32'd0);
      rd("arst_count", 5'd9, 32'd0);
      rd("arst_badvaddr", 5'd8, 32'd0);
      rst = 1'b0;
      ticks(2);
      rd("cold_count", 5'd9, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 Parameter EXC_ENTRY, default 32'hBFC0_0380, exception handler entry address.
REQ-002 Parameter COUNT_DIV, default 2, clock cycles per Count increment.
REQ-003 Reset is asynchronous and active-high, on a single clock.
REQ-004 cpu_clk_50M  in  1  sole clock; all state updates on its rising edge.
REQ-005 cpu_rst  in  1  asynchronous active-high reset.
REQ-006 wb_cp0_we  in  1  CP0 write enable from write-back.
REQ-007 wb_cp0_waddr  in  5  CP0 destination register number.
REQ-008 wb_cp0_wdata  in  32  CP0 write data.
REQ-009 raddr  in  5  CP0 read register number (MFC0).
REQ-010 rdata  out  32  combinational read of the current register state; unimplemented numbers read 0.
REQ-011 int_i  in  6  external hardware interrupt lines, level-sensitive.
REQ-012 exc_valid  in  1  exception commit strobe from memory stage.
REQ-013 exc_code  in  5  ExcCode (Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C).
REQ-014 exc_pc  in  32  PC of the excepting instruction.
REQ-015 exc_in_delay  in  1  excepting instruction is in a branch delay slot.
REQ-016 exc_badvaddr  in  32  faulting address for AdEL/AdES.
REQ-017 eret  in  1  ERET commit strobe.
REQ-018 int_req  out  1  interrupt pending and enabled (combinational).
REQ-019 flush  out  1  registered; pipeline flush, high one cycle after exc_valid or eret.
REQ-020 flush_pc  out  32  registered; EXC_ENTRY after exception, EPC after eret.
REQ-021 status_o, cause_o, epc_o  out  32 each  current Status, Cause and EPC.

Function
REQ-022 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
REQ-023 Writable Status bits: IM[15:8], EXL[1], IE[0]; BEV[22] is constant 1; all other bits read 0.
REQ-024 Writable Cause bits: IP[9:8] only; IP[15:10] = {int_i[5] | TI, int_i[4:0]}, sampled every cycle; TI = Cause[30].
REQ-025 Count increments by 1 every COUNT_DIV cycles using an internal divider, wrapping 32'hFFFF_FFFF -> 0.
REQ-026 A Count write loads wb_cp0_wdata and clears the divider phase; that cycle does not increment.
REQ-027 TI is set in the cycle after Count == Compare and holds until Compare is written.
REQ-028 A Compare write clears TI; if a match occurs in the same cycle, the write wins and TI stays 0.
REQ-029 int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
REQ-030 On exc_valid with Status.EXL = 0: EPC = exc_in_delay ? exc_pc - 4 : exc_pc; Cause.BD = exc_in_delay.
REQ-031 On exc_valid with Status.EXL = 1: EPC and BD are unchanged.
REQ-032 On every exc_valid: Status.EXL = 1; Cause.ExcCode[6:2] = exc_code; BadVAddr = exc_badvaddr only for AdEL/AdES.
REQ-033 On eret: Status.EXL = 0.
REQ-034 Priority per cycle: exc_valid > eret > wb_cp0_we; a lower-priority action targeting the same fields is discarded.
REQ-035 A CP0 write and an exception in the same cycle to disjoint fields (e.g. Compare vs. EPC) both take effect.
REQ-036 A write to a read-only or unimplemented register number has no effect.

Reset
REQ-037 On cpu_rst assertion, immediately and independent of the clock: Status = 32'h0040_0000; Cause, Count, Compare, EPC, BadVAddr, divider, flush = 0; flush_pc = 0.
REQ-038 Reset asserted mid-operation (pending TI, EXL set) clears all state at once; the first post-reset edge behaves as a cold start.

Verification
REQ-039 Reset, then read raddr 12 -> 32'h0040_0000; raddr 9 after 10 cycles -> 5.
REQ-040 Write Compare = 3, Count = 0 -> TI = 1, Cause[15] = 1; with IM7 = 1 and IE = 1, int_req = 1; rewriting Compare -> TI = 0.
REQ-041 exc_valid, code 0x0C, exc_pc 32'hBFC0_0100, in_delay 1 -> EPC = 32'hBFC0_00FC, BD = 1, EXL = 1, flush = 1 next cycle, flush_pc = 32'hBFC0_0380.
REQ-042 Second exception with EXL = 1 -> EPC unchanged, ExcCode updated; then eret -> EXL = 0, flush_pc = EPC.
REQ-043 Same cycle: exc_valid plus Status write clearing EXL -> EXL = 1; Count write plus exception -> Count takes wdata.
REQ-044 Assert cpu_rst between clock edges while TI = 1 -> all outputs at reset values before the next edge.
